// File: rtl/wc_tile_feeder.sv
// wc_tile_feeder: assembles overlapping N_IN-sample tiles from a W-bit sample
// stream, advancing M_OUT samples per tile, zero-padding the last tile of a row.
module wc_tile_feeder #(
    parameter int unsigned W     = 10,
    parameter int unsigned N_IN  = 7,
    parameter int unsigned M_OUT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    output logic [W*N_IN-1:0]   d_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic                d_last
);

    localparam int unsigned DW = W * N_IN;
    localparam int unsigned NW = $clog2(N_IN + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [NW-1:0] NEED_FULL   = NW'(N_IN);
    localparam logic [NW-1:0] NEED_STRIDE = NW'(M_OUT);
    localparam logic [NW-1:0] NEED_ONE    = NW'(1);

    logic [0:0]    state, state_nxt;
    logic [DW-1:0] window, window_nxt;
    logic [NW-1:0] need, need_nxt;
    logic [DW-1:0] d_data_nxt;
    logic          d_valid_nxt;
    logic          d_last_nxt;

    logic          out_blocked;
    logic          shift_en;
    logic [W-1:0]  shift_sample;
    logic [DW-1:0] shifted;
    logic          row_end;
    logic          completes;

    // Next-state logic: window shift, tile completion, row end / flush handling
    always_comb begin
        state_nxt    = state;
        window_nxt   = window;
        need_nxt     = need;
        d_data_nxt   = d_data;
        d_valid_nxt  = d_valid && !d_ready;
        d_last_nxt   = d_last && d_valid && !d_ready;
        s_ready      = 1'b0;
        shift_en     = 1'b0;
        shift_sample = '0;
        row_end      = 1'b0;

        // A completing shift must wait while the single output slot is occupied
        out_blocked  = (need == NEED_ONE) && d_valid && !d_ready;
        completes    = (need == NEED_ONE);

        if (state == ST_RUN) begin
            s_ready      = !out_blocked;
            shift_en     = s_valid && !out_blocked;
            shift_sample = s_data;
            row_end      = s_last;
        end else begin
            shift_en     = !out_blocked;
            shift_sample = '0;
            row_end      = 1'b1;
        end

        // Newest sample enters at the top, older samples move toward index 0
        shifted = {shift_sample, window[DW-1:W]};

        if (shift_en) begin
            if (completes) begin
                d_data_nxt  = shifted;
                d_valid_nxt = 1'b1;
                d_last_nxt  = row_end;
                if (row_end) begin
                    window_nxt = '0;
                    need_nxt   = NEED_FULL;
                    state_nxt  = ST_RUN;
                end else begin
                    window_nxt = shifted;
                    need_nxt   = NEED_STRIDE;
                end
            end else begin
                window_nxt = shifted;
                need_nxt   = need - NEED_ONE;
                if ((state == ST_RUN) && s_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            window  <= '0;
            need    <= NEED_FULL;
            d_data  <= '0;
            d_valid <= 1'b0;
            d_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            window  <= window_nxt;
            need    <= need_nxt;
            d_data  <= d_data_nxt;
            d_valid <= d_valid_nxt;
            d_last  <= d_last_nxt;
        end
    end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Testbench for wc_tile_feeder: row-level tile model plus directed literal checks.
module tb_wc_tile_feeder;

    localparam int W  = 10;
    localparam int N  = 7;
    localparam int M  = 3;
    localparam int DW = W * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [DW-1:0] d_data;
    logic          d_valid;
    logic          d_ready = 1'b1;
    logic          d_last;

    wc_tile_feeder #(.W(W), .N_IN(N), .M_OUT(M)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    logic [DW-1:0] log_data[$];
    bit            log_last[$];

    int row_buf[64];
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;
    int stall_cnt   = 0;
    int first_stall = -1;

    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_tile(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5,
                                              input int a6);
        int v[7];
        logic [DW-1:0] t;
        v = '{a0, a1, a2, a3, a4, a5, a6};
        t = '0;
        for (int i = 0; i < N; i++) t[W*i +: W] = W'(v[i]);
        return t;
    endfunction

    // Consumer-side ready generation
    always @(posedge clk) begin
        #1;
        d_ready = rand_ready ? (($urandom % 4) != 0) : ready_force;
    end

    // Compare process: every tile transfer against the model, plus hold stability
    always @(negedge clk) begin
        logic [DW-1:0] e;
        bit            l;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", DW'(d_valid), DW'(1));
                chk("hold_data", d_data, prev_data);
                chk("hold_last", DW'(d_last), DW'(prev_last));
            end
            if (d_valid && d_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tile: got %h expected none", d_data);
                end else begin
                    e = exp_data.pop_front();
                    l = exp_last.pop_front();
                    chk("tile_data", d_data, e);
                    chk("tile_last", DW'(d_last), DW'(l));
                end
                log_data.push_back(d_data);
                log_last.push_back(d_last);
            end
            stall_prev = d_valid && !d_ready;
            prev_data  = d_data;
            prev_last  = d_last;
        end
    end

    function automatic void fill_seq(input int start, input int len);
        for (int i = 0; i < len; i++) row_buf[i] = start + i;
    endfunction

    // Push the model's tiles for row_buf[0:len-1], then drive the row
    task automatic send_row(input int len, input int gap_pct);
        int ntiles;
        int t;
        logic [DW-1:0] tile;
        ntiles = (len <= N) ? 1 : 1 + (len - N + M - 1) / M;
        for (int k = 0; k < ntiles; k++) begin
            tile = '0;
            for (int i = 0; i < N; i++) begin
                if (k * M + i < len) tile[W*i +: W] = W'(row_buf[k*M + i]);
            end
            exp_data.push_back(tile);
            exp_last.push_back(k == ntiles - 1);
        end
        for (int i = 0; i < len; i++) begin
            if (($urandom % 100) < gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = W'(row_buf[i]);
            s_last  = (i == len - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                stall_cnt++;
                if (first_stall < 0) first_stall = row_buf[i];
                t++;
                if (t > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: sample %0d not accepted, expected acceptance", row_buf[i]);
                    $fatal(1, "sample stuck");
                end
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_data.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", DW'(exp_data.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!s_ready) lows++;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [DW-1:0] e, input bit l);
        if (idx < log_data.size()) begin
            chk(name, log_data[idx], e);
            chk({name, "_last"}, DW'(log_last[idx]), DW'(l));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: tile %0d missing, expected %h", name, idx, e);
        end
    endtask

    // Hold the consumer off for the first five cycles of the first tile
    task automatic pause_helper();
        int t = 0;
        @(negedge clk);
        while (!d_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("pause_valid", DW'(d_valid), DW'(1));
            chk("pause_data", d_data, mk_tile(1, 2, 3, 4, 5, 6, 7));
        end
        ready_force = 1'b1;
        @(negedge clk);
        chk("pause_release_d_ready", DW'(d_ready), DW'(1));
        chk("pause_release_s_ready", DW'(s_ready), DW'(1));
    endtask

    initial begin
        int base;
        int lows;
        int len;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_d_valid", DW'(d_valid), DW'(0));
        chk("reset_d_last", DW'(d_last), DW'(0));
        chk("reset_d_data", d_data, '0);
        chk("reset_s_ready", DW'(s_ready), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Row 1..13, consumer always ready
        base = log_data.size();
        fill_seq(1, 13);
        stall_cnt = 0;
        send_row(13, 0);
        drain();
        chk("row13_stalls", DW'(stall_cnt), DW'(0));
        chk_log("row13_t0", base,     mk_tile(1, 2, 3, 4, 5, 6, 7), 1'b0);
        chk_log("row13_t1", base + 1, mk_tile(4, 5, 6, 7, 8, 9, 10), 1'b0);
        chk_log("row13_t2", base + 2, mk_tile(7, 8, 9, 10, 11, 12, 13), 1'b1);

        // Row 1..8: one full tile, then a padded final tile after a 2-cycle flush
        base = log_data.size();
        fill_seq(1, 8);
        send_row(8, 0);
        count_low(5, lows);
        chk("row8_flush_low", DW'(lows), DW'(2));
        drain();
        chk_log("row8_t0", base,     mk_tile(1, 2, 3, 4, 5, 6, 7), 1'b0);
        chk_log("row8_t1", base + 1, mk_tile(4, 5, 6, 7, 8, 0, 0), 1'b1);

        // Short row 1..3, then a fresh row 11..17 must carry no stale samples
        base = log_data.size();
        fill_seq(1, 3);
        send_row(3, 0);
        count_low(6, lows);
        chk("row3_flush_low", DW'(lows), DW'(4));
        drain();
        fill_seq(11, 7);
        send_row(7, 0);
        drain();
        chk_log("row3_t0", base,     mk_tile(1, 2, 3, 0, 0, 0, 0), 1'b1);
        chk_log("row7_t0", base + 1, mk_tile(11, 12, 13, 14, 15, 16, 17), 1'b1);

        // Row 1..13 with consumer stalled for 5 cycles on the first tile
        base = log_data.size();
        ready_force = 1'b0;
        @(posedge clk); #1;
        fill_seq(1, 13);
        stall_cnt   = 0;
        first_stall = -1;
        fork
            send_row(13, 0);
            pause_helper();
        join
        drain();
        chk("pause_first_stall", DW'(first_stall), DW'(10));
        chk("pause_stall_cycles", DW'(stall_cnt), DW'(3));
        chk_log("pause_t0", base,     mk_tile(1, 2, 3, 4, 5, 6, 7), 1'b0);
        chk_log("pause_t1", base + 1, mk_tile(4, 5, 6, 7, 8, 9, 10), 1'b0);
        chk_log("pause_t2", base + 2, mk_tile(7, 8, 9, 10, 11, 12, 13), 1'b1);

        // Reset while flushing row 1..8: padded tile is discarded
        fill_seq(1, 8);
        send_row(8, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_flush_d_valid", DW'(d_valid), DW'(0));
        chk("rst_flush_s_ready", DW'(s_ready), DW'(1));
        chk("rst_flush_pending", DW'(exp_data.size()), DW'(1));
        exp_data.delete();
        exp_last.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        base = log_data.size();
        fill_seq(21, 7);
        send_row(7, 0);
        drain();
        chk_log("post_rst_t0", base, mk_tile(21, 22, 23, 24, 25, 26, 27), 1'b1);

        // Randomized rows, gaps and consumer backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) row_buf[i] = $urandom % 1024;
            send_row(len, 25);
        end
        drain();
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
